// File: rtl/lis3dh_poll_ctrl.sv
// lis3dh_poll_ctrl: brings up a LIS3DH through spi_master, then polls OUT_X.
// Define LIS3DH_POLL_SPI3W_EN to run the sensor in 3-wire SPI mode.
module lis3dh_poll_ctrl #(
  parameter logic [7:0]  WHOAMI_ID = 8'h33,
  parameter logic [7:0]  CTRL1_VAL = 8'h57,
  parameter int unsigned PERIOD    = 1000,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk_in,
  input  logic        nrst,
  input  logic        en,
  output logic        busy,
  output logic        id_ok,
  output logic        error,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        m_request,
  output logic [4:0]  m_nbits,
  output logic [31:0] m_mosi_data,
`ifdef LIS3DH_POLL_SPI3W_EN
  output logic        m_spi3w,
`endif
  input  logic        m_ready,
  input  logic [31:0] m_miso_data
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned WW = $clog2(PERIOD + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(PERIOD - 1);
  localparam logic [4:0] NB16 = 5'd15;
  localparam logic [4:0] NB24 = 5'd23;
  localparam logic [31:0] WHO_CMD = 32'h0000_8F00;
  localparam logic [31:0] RD_CMD = 32'h00E8_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WHO,
    S_CFG,
    S_RD,
    S_WAIT
`ifdef LIS3DH_POLL_SPI3W_EN
    , S_SIM
    , S_EXIT
`endif
  } state_t;

  typedef enum logic [1:0] {
    P_ISSUE,
    P_ACK,
    P_DONE
  } phase_t;

  state_t        state;
  state_t        comp_next;
  phase_t        phase;
  logic [TW-1:0] tmr;
  logic [WW-1:0] wcnt;
  logic          stop;
  logic          lock;
  logic          who_match;
  logic          leaving;
  logic [4:0]    cmd_nbits;
  logic [31:0]   cmd_mosi;
  logic          unused_miso;

  assign busy = (state != S_IDLE);
  assign who_match = (m_miso_data[7:0] == WHOAMI_ID);
  assign unused_miso = ^m_miso_data[31:16];

`ifdef LIS3DH_POLL_SPI3W_EN
  localparam state_t FIRST_ST = S_SIM;
  localparam state_t EXIT_ST = S_EXIT;
  assign leaving = (stop || !en) && (state != S_EXIT);
`else
  localparam state_t FIRST_ST = S_WHO;
  localparam state_t EXIT_ST = S_IDLE;
  assign leaving = stop || !en;
`endif

  always_comb begin
    cmd_nbits = NB16;
    cmd_mosi = WHO_CMD;
    unique case (state)
      S_CFG: cmd_mosi = {16'h0, 8'h20, CTRL1_VAL};
      S_RD: begin
        cmd_nbits = NB24;
        cmd_mosi = RD_CMD;
      end
`ifdef LIS3DH_POLL_SPI3W_EN
      S_SIM: cmd_mosi = 32'h0000_2301;
      S_EXIT: cmd_mosi = 32'h0000_2300;
`endif
      default: ;
    endcase
  end

  always_comb begin
    comp_next = S_IDLE;
    unique case (state)
      S_WHO: comp_next = who_match ? S_CFG : EXIT_ST;
      S_CFG: comp_next = S_RD;
      S_RD: comp_next = S_WAIT;
`ifdef LIS3DH_POLL_SPI3W_EN
      S_SIM: comp_next = S_WHO;
`endif
      default: ;
    endcase
    if (leaving) comp_next = EXIT_ST;
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      phase <= P_ISSUE;
      tmr <= '0;
      wcnt <= '0;
      stop <= 1'b0;
      lock <= 1'b0;
      id_ok <= 1'b0;
      error <= 1'b0;
      sample <= '0;
      sample_valid <= 1'b0;
      m_request <= 1'b0;
      m_nbits <= '0;
      m_mosi_data <= '0;
`ifdef LIS3DH_POLL_SPI3W_EN
      m_spi3w <= 1'b0;
`endif
    end else begin
      m_request <= 1'b0;
      sample_valid <= 1'b0;
      if (!en) lock <= 1'b0;
      unique case (state)
        S_IDLE: begin
          phase <= P_ISSUE;
          stop <= 1'b0;
          wcnt <= '0;
          tmr <= '0;
          if (en && !lock) begin
            id_ok <= 1'b0;
            error <= 1'b0;
            state <= FIRST_ST;
          end
        end
        S_WAIT: begin
          if (!en) begin
            state <= EXIT_ST;
          end else if (wcnt == WAIT_LAST) begin
            // request straight from the last wait cycle keeps the gap exact
            wcnt <= '0;
            state <= S_RD;
            if (m_ready) begin
              m_request <= 1'b1;
              m_nbits <= NB24;
              m_mosi_data <= RD_CMD;
              tmr <= '0;
              phase <= P_ACK;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          if (!en) stop <= 1'b1;
          unique case (phase)
            P_ISSUE: begin
              if (m_ready) begin
                m_request <= 1'b1;
                m_nbits <= cmd_nbits;
                m_mosi_data <= cmd_mosi;
                tmr <= '0;
                phase <= P_ACK;
              end
            end
            default: begin
              if (phase == P_DONE && m_ready) begin
                phase <= P_ISSUE;
                state <= comp_next;
                if (state == S_WHO) begin
                  if (who_match) begin
                    id_ok <= 1'b1;
                  end else begin
                    error <= 1'b1;
                    lock <= 1'b1;
                  end
                end
                if (state == S_RD) begin
                  sample <= {m_miso_data[7:0], m_miso_data[15:8]};
                  sample_valid <= 1'b1;
                end
`ifdef LIS3DH_POLL_SPI3W_EN
                if (state == S_SIM) m_spi3w <= 1'b1;
                if (state == S_EXIT) m_spi3w <= 1'b0;
`endif
              end else if (tmr == TMR_LAST) begin
                error <= 1'b1;
                lock <= 1'b1;
                phase <= P_ISSUE;
                state <= S_IDLE;
`ifdef LIS3DH_POLL_SPI3W_EN
                m_spi3w <= 1'b0;
`endif
              end else begin
                tmr <= tmr + 1'b1;
                if (!m_ready) phase <= P_DONE;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lis3dh_poll_ctrl.sv
// tb_lis3dh_poll_ctrl: table, directed and randomized checks of the LIS3DH
// poll sequencer driving a behavioural spi_master stub.
`timescale 1ns/1ps
module tb_lis3dh_poll_ctrl;
  localparam int T_PERIOD = 20;
  localparam int T_TIMEOUT = 40;
`ifdef LIS3DH_POLL_SPI3W_EN
  localparam int PRE = 1;
  localparam int POST = 1;
`else
  localparam int PRE = 0;
  localparam int POST = 0;
`endif

  logic clk_in = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;
  logic busy, id_ok, error, sample_valid, m_request, m_ready;
  logic [15:0] sample;
  logic [4:0] m_nbits;
  logic [31:0] m_mosi_data, m_miso_data;
`ifdef LIS3DH_POLL_SPI3W_EN
  logic m_spi3w;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  lis3dh_poll_ctrl #(
    .WHOAMI_ID(8'h33),
    .CTRL1_VAL(8'h57),
    .PERIOD(T_PERIOD),
    .TIMEOUT(T_TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .nrst(nrst),
    .en(en),
    .busy(busy),
    .id_ok(id_ok),
    .error(error),
    .sample(sample),
    .sample_valid(sample_valid),
    .m_request(m_request),
    .m_nbits(m_nbits),
    .m_mosi_data(m_mosi_data),
`ifdef LIS3DH_POLL_SPI3W_EN
    .m_spi3w(m_spi3w),
`endif
    .m_ready(m_ready),
    .m_miso_data(m_miso_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // spi_master stub: ready drops after a request, returns after a latency
  logic stuck = 1'b0;
  int lat_lo = 2;
  int lat_hi = 5;
  logic [7:0] who_resp = 8'h33;
  logic [7:0] x_l = 8'h00;
  logic [7:0] x_h = 8'h00;
  int st_cnt;
  logic [31:0] st_mosi;

  function automatic logic [31:0] resp(input logic [31:0] mosi);
    if (mosi == 32'h8F00) return {24'h0, who_resp};
    if (mosi == 32'hE80000) return {16'h0, x_l, x_h};
    return 32'h0;
  endfunction

  always @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      m_ready <= 1'b1;
      m_miso_data <= '0;
      st_cnt <= 0;
      st_mosi <= '0;
    end else if (m_ready) begin
      if (m_request) begin
        m_ready <= 1'b0;
        st_mosi <= m_mosi_data;
        st_cnt <= $urandom_range(lat_hi, lat_lo);
      end
    end else if (!stuck) begin
      if (st_cnt == 0) begin
        m_ready <= 1'b1;
        m_miso_data <= resp(st_mosi);
      end else begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  logic prev_req = 1'b0;
  logic prev_sv = 1'b0;
  logic sv_pend = 1'b0;
  int sv_cyc = 0;
  int req_cyc = 0;
  logic [31:0] req_q[$];
  logic [4:0] nb_q[$];

  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    prev_req <= nrst & m_request;
    prev_sv <= nrst & sample_valid;
    if (nrst) begin
      if (m_request) begin
        req_q.push_back(m_mosi_data);
        nb_q.push_back(m_nbits);
        chk("req_pulse", 32'(prev_req), 32'd0);
        chk("req_ready", 32'(m_ready), 32'd1);
        if (sv_pend && m_mosi_data == 32'hE80000)
          chk("period", 32'(cyc + 1 - sv_cyc), 32'(T_PERIOD));
        sv_pend <= 1'b0;
        req_cyc <= cyc + 1;
`ifdef LIS3DH_POLL_SPI3W_EN
        chk("spi3w_req", 32'(m_spi3w), 32'(m_mosi_data != 32'h2301));
`endif
      end
      if (!m_ready && !m_request)
        chk("held_mosi", m_mosi_data, st_mosi);
      if (sample_valid) begin
        chk("sv_pulse", 32'(prev_sv), 32'd0);
        sv_pend <= 1'b1;
        sv_cyc <= cyc + 1;
      end
      if (!busy) sv_pend <= 1'b0;
`ifdef LIS3DH_POLL_SPI3W_EN
      if (!busy) chk("spi3w_idle", 32'(m_spi3w), 32'd0);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic wait_sv(input int budget, input string name);
    int i;
    i = 0;
    do begin tick(); i++; end while (!sample_valid && i < budget);
    chk(name, 32'(sample_valid), 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] mosi, input int budget,
                          input string name);
    int i;
    i = 0;
    do begin tick(); i++; end
    while (!(m_request && m_mosi_data == mosi) && i < budget);
    chk(name, 32'(m_request && m_mosi_data == mosi), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    while (busy && i < budget) begin tick(); i++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_err(input int budget, input string name);
    int i;
    i = 0;
    while (!error && i < budget) begin tick(); i++; end
    chk(name, 32'(error), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  who;
    logic [7:0]  xl;
    logic [7:0]  xh;
    logic        exp_ok;
    logic        exp_err;
    logic [15:0] exp_sample;
  } vec_t;

  vec_t tbl[6];
  int i, n, k_rd;
  bit mid, bad;
  logic [15:0] exp_s;
  logic [31:0] exp_req[$];
  logic [4:0] exp_nb[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'h33, 8'h34, 8'h12, 1'b1, 1'b0, 16'h1234};
    tbl[1] = '{8'h32, 8'h00, 8'h00, 1'b0, 1'b1, 16'h1234};
    tbl[2] = '{8'h33, 8'hFF, 8'h00, 1'b1, 1'b0, 16'h00FF};
    tbl[3] = '{8'hAA, 8'h11, 8'h22, 1'b0, 1'b1, 16'h00FF};
    tbl[4] = '{8'h33, 8'h00, 8'h80, 1'b1, 1'b0, 16'h8000};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 16'h8000};

    // reset state
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id_ok", 32'(id_ok), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_sv", 32'(sample_valid), 0);
    chk("rst_req", 32'(m_request), 0);
    chk("rst_nbits", 32'(m_nbits), 0);
    chk("rst_mosi", m_mosi_data, 0);
    nrst = 1'b1;
    tick(3);
    chk("idle_en0", 32'(busy), 0);

    // basic bring-up and two reads
    who_resp = 8'h33;
    x_l = 8'h34;
    x_h = 8'h12;
    req_q.delete();
    nb_q.delete();
    en = 1'b1;
    wait_sv(300, "t1_sv1");
    chk("t1_sample", 32'(sample), 32'h1234);
    chk("t1_id_ok", 32'(id_ok), 1);
    chk("t1_error", 32'(error), 0);
    wait_sv(300, "t1_sv2");
    chk("t1_nreq", 32'(req_q.size()), 32'(PRE + 4));
    chk("t1_who", req_q[PRE], 32'h8F00);
    chk("t1_who_nb", 32'(nb_q[PRE]), 15);
    chk("t1_cfg", req_q[PRE + 1], 32'h2057);
    chk("t1_cfg_nb", 32'(nb_q[PRE + 1]), 15);
    chk("t1_rd", req_q[PRE + 2], 32'hE80000);
    chk("t1_rd_nb", 32'(nb_q[PRE + 2]), 23);
    en = 1'b0;
`ifndef LIS3DH_POLL_SPI3W_EN
    tick();
    chk("t1_wait_stop", 32'(busy), 0);
`endif
    wait_idle(60, "t1_idle");
    tick(2);

    // table of WHOAMI / sample patterns
    for (int r = 0; r < 6; r++) begin
      who_resp = tbl[r].who;
      x_l = tbl[r].xl;
      x_h = tbl[r].xh;
      req_q.delete();
      en = 1'b1;
      tick(2);
      i = 0;
      while (!sample_valid && !error && i < 300) begin tick(); i++; end
      chk("t2_event", 32'(sample_valid | error), 1);
      if (tbl[r].exp_err) begin
        wait_idle(60, "t2_err_idle");
        tick(20);
        chk("t2_no_restart", 32'(busy), 0);
        chk("t2_nreq", 32'(req_q.size()), 32'(PRE + 1 + POST));
      end else begin
        chk("t2_busy", 32'(busy), 1);
      end
      chk("t2_id_ok", 32'(id_ok), 32'(tbl[r].exp_ok));
      chk("t2_error", 32'(error), 32'(tbl[r].exp_err));
      chk("t2_sample", 32'(sample), 32'(tbl[r].exp_sample));
      en = 1'b0;
      wait_idle(60, "t2_idle");
      tick(2);
    end

    // ready stuck low: timeout, then restart via en toggle
    who_resp = 8'h33;
    stuck = 1'b1;
    en = 1'b1;
    i = 0;
    do begin tick(); i++; end while (!m_request && i < 20);
    chk("to_req", 32'(m_request), 1);
    wait_err(T_TIMEOUT + 20, "to_error");
    chk("to_cycles", 32'(cyc - req_cyc), 32'(T_TIMEOUT));
    chk("to_busy", 32'(busy), 0);
    tick(10);
    chk("to_no_restart", 32'(busy), 0);
    stuck = 1'b0;
    tick(20);
    en = 1'b0;
    tick(2);
    chk("to_sticky", 32'(error), 1);
    en = 1'b1;
    tick(3);
    chk("to_cleared", 32'(error), 0);
    chk("to_running", 32'(busy), 1);
    wait_sv(300, "to_run_sv");
    chk("to_run_id", 32'(id_ok), 1);
    en = 1'b0;
    wait_idle(60, "to_idle");
    tick(2);

    // en dropped during an X read
    x_l = 8'hC3;
    x_h = 8'h5A;
    en = 1'b1;
    wait_req(32'hE80000, 300, "mid_rd_req");
    en = 1'b0;
    wait_sv(50, "mid_sv");
    chk("mid_sample", 32'(sample), 32'h5AC3);
`ifndef LIS3DH_POLL_SPI3W_EN
    chk("mid_busy", 32'(busy), 0);
`endif
    wait_idle(60, "mid_idle");
    n = req_q.size();
    tick(50);
    chk("mid_noreq", 32'(req_q.size()), 32'(n));

    // nrst asserted during the CTRL_REG1 write
    en = 1'b1;
    wait_req(32'h2057, 300, "nr_cfg_req");
    nrst = 1'b0;
    #1;
    chk("nr_busy", 32'(busy), 0);
    chk("nr_id_ok", 32'(id_ok), 0);
    chk("nr_error", 32'(error), 0);
    chk("nr_sample", 32'(sample), 0);
    chk("nr_sv", 32'(sample_valid), 0);
    chk("nr_req", 32'(m_request), 0);
    chk("nr_nbits", 32'(m_nbits), 0);
    chk("nr_mosi", m_mosi_data, 0);
    en = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(2);

    // randomized runs against a transaction-list model
    for (int r = 0; r < 10; r++) begin
      k_rd = $urandom_range(3, 1);
      mid = 1'($urandom_range(1, 0));
      bad = ($urandom_range(3, 0) == 0);
      lat_lo = $urandom_range(3, 1);
      lat_hi = lat_lo + $urandom_range(4, 0);
      who_resp = bad ? (8'h33 ^ 8'($urandom_range(255, 1))) : 8'h33;
      exp_req.delete();
      exp_nb.delete();
      if (PRE != 0) begin exp_req.push_back(32'h2301); exp_nb.push_back(5'(16 - 1)); end
      exp_req.push_back(32'h8F00);
      exp_nb.push_back(5'(16 - 1));
      if (!bad) begin
        exp_req.push_back(32'h2057);
        exp_nb.push_back(5'(16 - 1));
        for (int j = 0; j < k_rd; j++) begin
          exp_req.push_back(32'hE80000);
          exp_nb.push_back(5'(24 - 1));
        end
      end
      if (POST != 0) begin exp_req.push_back(32'h2300); exp_nb.push_back(5'(16 - 1)); end
      req_q.delete();
      nb_q.delete();
      x_l = 8'($urandom);
      x_h = 8'($urandom);
      en = 1'b1;
      if (bad) begin
        wait_err(300, "rnd_err");
        chk("rnd_bad_id", 32'(id_ok), 0);
      end else begin
        for (int j = 0; j < k_rd; j++) begin
          if (j > 0) begin
            x_l = 8'($urandom);
            x_h = 8'($urandom);
          end
          exp_s = {x_h, x_l};
          if (mid && j == k_rd - 1) begin
            wait_req(32'hE80000, 300, "rnd_rd_req");
            en = 1'b0;
          end
          wait_sv(300, "rnd_sv");
          chk("rnd_sample", 32'(sample), 32'(exp_s));
        end
        chk("rnd_id_ok", 32'(id_ok), 1);
      end
      en = 1'b0;
      wait_idle(100, "rnd_idle");
      tick(2);
      chk("rnd_nreq", 32'(req_q.size()), 32'(exp_req.size()));
      foreach (exp_req[j]) begin
        chk("rnd_mosi", req_q[j], exp_req[j]);
        chk("rnd_nbits", 32'(nb_q[j]), 32'(exp_nb[j]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
